// File: rtl/qtree_pkg.sv
// ---------------------------------------------------------------------------
// qtree_pkg
//   Shared definitions for the qtree lookup-result path.
//   - qtree_resp_t : canonical result entry layout {match, bypass, addr} at
//                    the default tree widths.
//   - width helpers used by qtree_resp_buf and qtree_sfifo_mem to size
//     entries, FIFO indices and the credit counter.
// ---------------------------------------------------------------------------
package qtree_pkg;

  localparam int QTREE_ADDR_WIDTH   = 8;
  localparam int QTREE_BYPASS_WIDTH = 1;

  typedef struct packed {
    logic                          match;
    logic [QTREE_BYPASS_WIDTH-1:0] bypass;
    logic [QTREE_ADDR_WIDTH-1:0]   addr;
  } qtree_resp_t;

  // Bits needed for one {match, bypass, addr} entry at arbitrary widths.
  // Field order matches qtree_resp_t, so default-width entries are
  // bit-identical to the struct.
  function automatic int qtree_entry_width(input int addr_w, input int bypass_w);
    return 1 + bypass_w + addr_w;
  endfunction

  // Index width for a DEPTH-entry array; never below 1 bit.
  function automatic int qtree_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int qtree_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/qtree_sfifo_mem.sv
// ---------------------------------------------------------------------------
// qtree_sfifo_mem
//   DEPTH x WIDTH register array backing the result FIFO. One synchronous
//   write port and one asynchronous read port. Storage is not reset; only
//   the control state in the owning FIFO is.
//
//   Ports
//     clk_i      in   1      clock, rising edge
//     wr_en_i    in   1      write enable
//     wr_idx_i   in   IDX_W  write index
//     wr_data_i  in   WIDTH  write data
//     rd_idx_i   in   IDX_W  read index
//     rd_data_o  out  WIDTH  read data (combinational from the array)
// ---------------------------------------------------------------------------
module qtree_sfifo_mem
  import qtree_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = $bits(qtree_resp_t),
  parameter int IDX_W = qtree_idx_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // A write landing on the slot being read this cycle is seen only after
  // the edge, which is what keeps a same-cycle push/pop on a full FIFO safe.
  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/qtree_resp_buf.sv
// ---------------------------------------------------------------------------
// qtree_resp_buf
//   Response buffer behind the qtree lookup pipeline. Upstream issues
//   lookups against a credit counter sized to the buffer, so a well-behaved
//   upstream can never overrun it. Results returning from the tree are
//   queued in arrival order and handed out over a valid/ready interface.
//   Overruns and credit-less issues are recorded in sticky error flags.
//
//   Optional feature (macro QTREE_RESP_BUF_STATS_EN):
//     adds saturating 32-bit counters of pushed match / miss results.
//
//   Parameters
//     ADDR_WIDTH    result address width
//     BYPASS_WIDTH  bypass tag width
//     DEPTH         entries, power of two in 2..256
//
//   Ports
//     clk_i             in   1             clock, rising edge
//     rst_i             in   1             synchronous active-high reset
//     lookup_issue_i    in   1             a lookup is launched this cycle
//     credit_ok_o       out  1             a lookup may be launched
//     lookup_valid_i    in   1             tree delivers a result
//     lookup_match_i    in   1             result is a match
//     lookup_bypass_i   in   BYPASS_WIDTH  result bypass tag
//     lookup_addr_i     in   ADDR_WIDTH    result address
//     out_valid_o       out  1             head entry available
//     out_ready_i       in   1             consumer takes the head entry
//     out_match_o       out  1             head match
//     out_bypass_o      out  BYPASS_WIDTH  head bypass tag
//     out_addr_o        out  ADDR_WIDTH    head address
//     err_overflow_o    out  1             sticky: a result was dropped
//     err_credit_o      out  1             sticky: issue without credit
//     stat_match_cnt_o  out  32            (stats build) pushed matches
//     stat_miss_cnt_o   out  32            (stats build) pushed misses
// ---------------------------------------------------------------------------
module qtree_resp_buf
  import qtree_pkg::*;
#(
  parameter int ADDR_WIDTH   = QTREE_ADDR_WIDTH,
  parameter int BYPASS_WIDTH = QTREE_BYPASS_WIDTH,
  parameter int DEPTH        = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    lookup_issue_i,
  output logic                    credit_ok_o,
  input  logic                    lookup_valid_i,
  input  logic                    lookup_match_i,
  input  logic [BYPASS_WIDTH-1:0] lookup_bypass_i,
  input  logic [ADDR_WIDTH-1:0]   lookup_addr_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    out_match_o,
  output logic [BYPASS_WIDTH-1:0] out_bypass_o,
  output logic [ADDR_WIDTH-1:0]   out_addr_o,
  output logic                    err_overflow_o,
  output logic                    err_credit_o
`ifdef QTREE_RESP_BUF_STATS_EN
  ,
  output logic [31:0]             stat_match_cnt_o,
  output logic [31:0]             stat_miss_cnt_o
`endif
);

  localparam int ENTRY_W = qtree_entry_width(ADDR_WIDTH, BYPASS_WIDTH);
  localparam int IDX_W   = qtree_idx_width(DEPTH);
  localparam int CNT_W   = qtree_cnt_width(DEPTH);

  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W:0]   PTR_ONE    = (IDX_W + 1)'(1);

  // Pointers carry one bit beyond the index so full and empty differ.
  logic [IDX_W:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   credit_q, credit_next;
  logic               err_overflow_q, err_credit_q;

  logic               fifo_empty, fifo_full;
  logic               push, pop, issue_ok;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  // out_valid_o comes from registered pointers only, so a push never
  // shows up in its own cycle.
  assign out_valid_o = !fifo_empty;
  assign pop         = out_valid_o && out_ready_i;
  // A full FIFO still accepts a result when the head leaves this cycle.
  assign push        = lookup_valid_i && (!fifo_full || pop);
  assign issue_ok    = lookup_issue_i && (credit_q != '0);

  assign wr_entry = {lookup_match_i, lookup_bypass_i, lookup_addr_i};

  qtree_sfifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (push),
    .wr_idx_i  (wr_ptr_q[IDX_W-1:0]),
    .wr_data_i (wr_entry),
    .rd_idx_i  (rd_ptr_q[IDX_W-1:0]),
    .rd_data_o (rd_entry)
  );

  assign out_match_o  = rd_entry[ENTRY_W-1];
  assign out_bypass_o = rd_entry[ADDR_WIDTH +: BYPASS_WIDTH];
  assign out_addr_o   = rd_entry[ADDR_WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Credit moves by +pop -issue_ok. The increment saturates at DEPTH so
  // results arriving without a matching issue cannot push it out of range;
  // a rejected issue never decrements, so the counter cannot wrap below 0.
  always_comb begin
    credit_next = credit_q;
    if (pop && !issue_ok) begin
      if (credit_q != CREDIT_MAX) begin
        credit_next = credit_q + CNT_ONE;
      end
    end else if (issue_ok && !pop) begin
      credit_next = credit_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credit_q <= CREDIT_MAX;
    end else begin
      credit_q <= credit_next;
    end
  end

  assign credit_ok_o = (credit_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_overflow_q <= 1'b0;
      err_credit_q   <= 1'b0;
    end else begin
      if (lookup_valid_i && fifo_full && !pop) begin
        err_overflow_q <= 1'b1;
      end
      if (lookup_issue_i && (credit_q == '0)) begin
        err_credit_q <= 1'b1;
      end
    end
  end

  assign err_overflow_o = err_overflow_q;
  assign err_credit_o   = err_credit_q;

`ifdef QTREE_RESP_BUF_STATS_EN
  logic [31:0] stat_match_q, stat_miss_q;

  // Only results that actually enter the FIFO are counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_match_q <= '0;
      stat_miss_q  <= '0;
    end else if (push) begin
      if (lookup_match_i) begin
        if (stat_match_q != 32'hFFFF_FFFF) begin
          stat_match_q <= stat_match_q + 32'd1;
        end
      end else begin
        if (stat_miss_q != 32'hFFFF_FFFF) begin
          stat_miss_q <= stat_miss_q + 32'd1;
        end
      end
    end
  end

  assign stat_match_cnt_o = stat_match_q;
  assign stat_miss_cnt_o  = stat_miss_q;
`endif

endmodule

// File: tb/tb_qtree_resp_buf.sv
// ---------------------------------------------------------------------------
// tb_qtree_resp_buf
//   Bench for qtree_resp_buf at DEPTH=4: directed scenarios followed by a
//   randomized run against a queue-based reference model. Stats checks are
//   included when QTREE_RESP_BUF_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_qtree_resp_buf;

  localparam int ADDR_WIDTH   = 8;
  localparam int BYPASS_WIDTH = 1;
  localparam int DEPTH        = 4;
  localparam int ENTRY_W      = 1 + BYPASS_WIDTH + ADDR_WIDTH;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    lookup_issue_i = 1'b0;
  logic                    credit_ok_o;
  logic                    lookup_valid_i = 1'b0;
  logic                    lookup_match_i = 1'b0;
  logic [BYPASS_WIDTH-1:0] lookup_bypass_i = '0;
  logic [ADDR_WIDTH-1:0]   lookup_addr_i = '0;
  logic                    out_valid_o;
  logic                    out_ready_i = 1'b0;
  logic                    out_match_o;
  logic [BYPASS_WIDTH-1:0] out_bypass_o;
  logic [ADDR_WIDTH-1:0]   out_addr_o;
  logic                    err_overflow_o;
  logic                    err_credit_o;
`ifdef QTREE_RESP_BUF_STATS_EN
  logic [31:0]             stat_match_cnt_o;
  logic [31:0]             stat_miss_cnt_o;
`endif

  int vectors     = 0;
  int miscompares = 0;

  qtree_resp_buf #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .BYPASS_WIDTH (BYPASS_WIDTH),
    .DEPTH        (DEPTH)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .lookup_issue_i  (lookup_issue_i),
    .credit_ok_o     (credit_ok_o),
    .lookup_valid_i  (lookup_valid_i),
    .lookup_match_i  (lookup_match_i),
    .lookup_bypass_i (lookup_bypass_i),
    .lookup_addr_i   (lookup_addr_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_match_o     (out_match_o),
    .out_bypass_o    (out_bypass_o),
    .out_addr_o      (out_addr_o),
    .err_overflow_o  (err_overflow_o),
    .err_credit_o    (err_credit_o)
`ifdef QTREE_RESP_BUF_STATS_EN
    ,
    .stat_match_cnt_o (stat_match_cnt_o),
    .stat_miss_cnt_o  (stat_miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge; inputs change and outputs
  // are sampled here, away from the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    lookup_issue_i  = 1'b0;
    lookup_valid_i  = 1'b0;
    lookup_match_i  = 1'b0;
    lookup_bypass_i = '0;
    lookup_addr_i   = '0;
    out_ready_i     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid_o); end
    vectors++; if (credit_ok_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_credit_ok: got %b want 1", credit_ok_o); end
    vectors++; if (err_overflow_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err_overflow: got %b want 0", err_overflow_o); end
    vectors++; if (err_credit_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err_credit: got %b want 0", err_credit_o); end
  endtask

  // Four issues drain the credit, four results stream through with ready
  // held high, and the credit comes back to exactly four.
  task automatic test_credit_flow();
    logic exp_ok;
    logic [ADDR_WIDTH-1:0] exp_addr;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      lookup_issue_i = 1'b1;
      tick();
      exp_ok = (i < 3);
      vectors++; if (credit_ok_o !== exp_ok) begin miscompares++; $display("[TB] FAIL flow_issue_credit_ok[%0d]: got %b want %b", i, credit_ok_o, exp_ok); end
    end
    lookup_issue_i = 1'b0;
    out_ready_i    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lookup_valid_i  = 1'b1;
      lookup_addr_i   = ADDR_WIDTH'(8'h20 + i);
      lookup_match_i  = i[0];
      lookup_bypass_i = BYPASS_WIDTH'(i[1]);
      if (i == 0) begin
        vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flow_no_fallthrough: got %b want 0", out_valid_o); end
      end
      tick();
      exp_addr = ADDR_WIDTH'(8'h20 + i);
      vectors++; if (out_valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL flow_out_valid[%0d]: got %b want 1", i, out_valid_o); end
      vectors++; if (out_addr_o !== exp_addr) begin miscompares++; $display("[TB] FAIL flow_out_addr[%0d]: got %h want %h", i, out_addr_o, exp_addr); end
      vectors++; if (out_match_o !== i[0]) begin miscompares++; $display("[TB] FAIL flow_out_match[%0d]: got %b want %b", i, out_match_o, i[0]); end
    end
    lookup_valid_i = 1'b0;
    tick();
    out_ready_i = 1'b0;
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flow_drained: got %b want 0", out_valid_o); end
    for (int i = 0; i < 4; i++) begin
      lookup_issue_i = 1'b1;
      tick();
      exp_ok = (i < 3);
      vectors++; if (credit_ok_o !== exp_ok) begin miscompares++; $display("[TB] FAIL flow_credit_back[%0d]: got %b want %b", i, credit_ok_o, exp_ok); end
    end
    lookup_issue_i = 1'b0;
    vectors++; if (err_credit_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flow_err_credit: got %b want 0", err_credit_o); end
  endtask

  // Fill while stalled, overrun once, then drain and confirm nothing moved.
  task automatic test_overflow();
    logic [ADDR_WIDTH-1:0] exp_addr;
    do_reset();
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lookup_valid_i = 1'b1;
      lookup_addr_i  = ADDR_WIDTH'(8'h11 + i);
      tick();
      vectors++; if (out_addr_o !== 8'h11) begin miscompares++; $display("[TB] FAIL ovf_head_stable[%0d]: got %h want 11", i, out_addr_o); end
    end
    lookup_valid_i = 1'b0;
    vectors++; if (err_overflow_o !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_flag: got %b want 1", err_overflow_o); end
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr = ADDR_WIDTH'(8'h11 + i);
      vectors++; if (out_valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_drain_valid[%0d]: got %b want 1", i, out_valid_o); end
      vectors++; if (out_addr_o !== exp_addr) begin miscompares++; $display("[TB] FAIL ovf_drain_addr[%0d]: got %h want %h", i, out_addr_o, exp_addr); end
      tick();
    end
    out_ready_i = 1'b0;
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_drained: got %b want 0", out_valid_o); end
    vectors++; if (err_overflow_o !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_sticky: got %b want 1", err_overflow_o); end
  endtask

  // Push and pop together on a full buffer: no overflow, still full.
  task automatic test_full_push_pop();
    logic [ADDR_WIDTH-1:0] exp_addr;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      lookup_valid_i = 1'b1;
      lookup_addr_i  = ADDR_WIDTH'(8'h31 + i);
      tick();
    end
    lookup_addr_i = 8'h35;
    out_ready_i   = 1'b1;
    tick();
    lookup_valid_i = 1'b0;
    out_ready_i    = 1'b0;
    vectors++; if (err_overflow_o !== 1'b0) begin miscompares++; $display("[TB] FAIL fpp_no_overflow: got %b want 0", err_overflow_o); end
    vectors++; if (out_addr_o !== 8'h32) begin miscompares++; $display("[TB] FAIL fpp_head: got %h want 32", out_addr_o); end
    lookup_valid_i = 1'b1;
    lookup_addr_i  = 8'h36;
    tick();
    lookup_valid_i = 1'b0;
    vectors++; if (err_overflow_o !== 1'b1) begin miscompares++; $display("[TB] FAIL fpp_still_full: got %b want 1", err_overflow_o); end
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr = ADDR_WIDTH'(8'h32 + i);
      vectors++; if (out_addr_o !== exp_addr || out_valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL fpp_drain[%0d]: got v=%b %h want v=1 %h", i, out_valid_o, out_addr_o, exp_addr); end
      tick();
    end
    out_ready_i = 1'b0;
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL fpp_drained: got %b want 0", out_valid_o); end
  endtask

  // Issue at zero credit is rejected and flagged; a pop brings credit back.
  task automatic test_credit_err();
    do_reset();
    lookup_valid_i = 1'b1;
    lookup_addr_i  = 8'h42;
    for (int i = 0; i < 4; i++) begin
      lookup_issue_i = 1'b1;
      tick();
      lookup_valid_i = 1'b0;
    end
    vectors++; if (credit_ok_o !== 1'b0) begin miscompares++; $display("[TB] FAIL cerr_exhausted: got %b want 0", credit_ok_o); end
    tick();
    lookup_issue_i = 1'b0;
    vectors++; if (err_credit_o !== 1'b1) begin miscompares++; $display("[TB] FAIL cerr_flag: got %b want 1", err_credit_o); end
    vectors++; if (credit_ok_o !== 1'b0) begin miscompares++; $display("[TB] FAIL cerr_no_wrap: got %b want 0", credit_ok_o); end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    vectors++; if (credit_ok_o !== 1'b1) begin miscompares++; $display("[TB] FAIL cerr_restored: got %b want 1", credit_ok_o); end
    lookup_issue_i = 1'b1;
    tick();
    lookup_issue_i = 1'b0;
    vectors++; if (credit_ok_o !== 1'b0) begin miscompares++; $display("[TB] FAIL cerr_one_credit: got %b want 0", credit_ok_o); end
    vectors++; if (err_credit_o !== 1'b1) begin miscompares++; $display("[TB] FAIL cerr_sticky: got %b want 1", err_credit_o); end
  endtask

  // Reset wins over a concurrent push, pop and issue with 3 entries held.
  task automatic test_reset_mid();
    logic exp_ok;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      lookup_issue_i = 1'b1;
      lookup_valid_i = 1'b1;
      lookup_addr_i  = ADDR_WIDTH'(8'h50 + i);
      tick();
    end
    lookup_issue_i = 1'b0;
    lookup_valid_i = 1'b0;
    out_ready_i    = 1'b1;
    tick();
    vectors++; if (err_overflow_o !== 1'b1 || err_credit_o !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_pre_flags: got ovf=%b cred=%b want 1 1", err_overflow_o, err_credit_o); end
    rst_i          = 1'b1;
    lookup_valid_i = 1'b1;
    lookup_issue_i = 1'b1;
    lookup_addr_i  = 8'h5F;
    tick();
    rst_i = 1'b0;
    idle_inputs();
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_out_valid: got %b want 0", out_valid_o); end
    vectors++; if (err_overflow_o !== 1'b0 || err_credit_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_flags: got ovf=%b cred=%b want 0 0", err_overflow_o, err_credit_o); end
    tick();
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_push_discarded: got %b want 0", out_valid_o); end
    for (int i = 0; i < 4; i++) begin
      lookup_issue_i = 1'b1;
      tick();
      exp_ok = (i < 3);
      vectors++; if (credit_ok_o !== exp_ok) begin miscompares++; $display("[TB] FAIL rmid_credit[%0d]: got %b want %b", i, credit_ok_o, exp_ok); end
    end
    lookup_issue_i = 1'b0;
  endtask

`ifdef QTREE_RESP_BUF_STATS_EN
  task automatic test_stats();
    do_reset();
    vectors++; if (stat_match_cnt_o !== 32'd0 || stat_miss_cnt_o !== 32'd0) begin miscompares++; $display("[TB] FAIL stats_reset: got %0d %0d want 0 0", stat_match_cnt_o, stat_miss_cnt_o); end
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lookup_valid_i = 1'b1;
      lookup_match_i = (i < 5);
      lookup_addr_i  = ADDR_WIDTH'(i);
      tick();
    end
    idle_inputs();
    tick();
    vectors++; if (stat_match_cnt_o !== 32'd5) begin miscompares++; $display("[TB] FAIL stats_match: got %0d want 5", stat_match_cnt_o); end
    vectors++; if (stat_miss_cnt_o !== 32'd3) begin miscompares++; $display("[TB] FAIL stats_miss: got %0d want 3", stat_miss_cnt_o); end
  endtask
`endif

  // Random traffic against a model built from a queue and an integer
  // credit count.
  task automatic test_random();
    logic [ENTRY_W-1:0] mq[$];
    logic [ENTRY_W-1:0] head;
    int  mcredit;
    bit  movf, mcred, mpop, mfull, missue_ok;
    do_reset();
    mcredit = DEPTH;
    movf    = 1'b0;
    mcred   = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      lookup_issue_i  = ($urandom_range(0, 99) < 30);
      lookup_valid_i  = ($urandom_range(0, 99) < 45);
      out_ready_i     = ($urandom_range(0, 99) < 55);
      lookup_match_i  = 1'($urandom);
      lookup_bypass_i = BYPASS_WIDTH'($urandom);
      lookup_addr_i   = ADDR_WIDTH'($urandom);

      vectors++; if (out_valid_o !== (mq.size() > 0)) begin miscompares++; $display("[TB] FAIL rnd_out_valid@%0d: got %b want %b", cyc, out_valid_o, (mq.size() > 0)); end
      vectors++; if (credit_ok_o !== (mcredit != 0)) begin miscompares++; $display("[TB] FAIL rnd_credit_ok@%0d: got %b want %b", cyc, credit_ok_o, (mcredit != 0)); end
      vectors++; if (err_overflow_o !== movf || err_credit_o !== mcred) begin miscompares++; $display("[TB] FAIL rnd_flags@%0d: got ovf=%b cred=%b want %b %b", cyc, err_overflow_o, err_credit_o, movf, mcred); end
      if (mq.size() > 0) begin
        head = mq[0];
        vectors++; if ({out_match_o, out_bypass_o, out_addr_o} !== head) begin miscompares++; $display("[TB] FAIL rnd_head@%0d: got %h want %h", cyc, {out_match_o, out_bypass_o, out_addr_o}, head); end
      end

      mpop      = (mq.size() > 0) && out_ready_i;
      mfull     = (mq.size() == DEPTH);
      missue_ok = lookup_issue_i && (mcredit > 0);
      if (lookup_issue_i && mcredit == 0) mcred = 1'b1;
      if (lookup_valid_i && mfull && !mpop) movf = 1'b1;
      mcredit = mcredit + (mpop ? 1 : 0) - (missue_ok ? 1 : 0);
      if (mcredit > DEPTH) mcredit = DEPTH;
      if (mpop) void'(mq.pop_front());
      if (lookup_valid_i && (!mfull || mpop))
        mq.push_back({lookup_match_i, lookup_bypass_i, lookup_addr_i});
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    $display("[TB] qtree_resp_buf bench, DEPTH=%0d", DEPTH);
    test_reset();
    test_credit_flow();
    test_overflow();
    test_full_push_pop();
    test_credit_err();
    test_reset_mid();
`ifdef QTREE_RESP_BUF_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
